// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Hazard-detection and forwarding controller for the 5-stage F/D/X/M/W
//   pipeline. Keeps a shadow copy of the destination/load info of the
//   instructions in D/X and X/M. It produces:
//     - registered X-stage forwarding selects
//     - load-use stalls of LOAD_STALLS cycles
//     - taken-branch flushes
//     - saturating stall/flush statistics
//
// Ports
//   clock, reset              single clock, synchronous active-high reset
//   d_valid                   F/D holds a real instruction
//   d_rs, d_rt                source specifiers of the instruction in D
//   d_uses_rs, d_uses_rt      instruction in D reads rs / rt
//   d_dst, d_rwe, d_is_load   destination, reg-write enable, load flag
//   x_branch_taken            instruction in X is a taken branch/jump
//   stall                     hold PC and F/D this cycle (combinational)
//   bubble_dx                 load a NOP into D/X at next edge (combinational)
//   flush                     squash F/D and D/X at next edge (combinational)
//   fwd_a_sel, fwd_b_sel      X operand source: 00 D/X, 01 MX, 10 WX (registered)
//   stall_cycles, flush_count saturating statistics counters (registered)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic                  d_uses_rs,
  input  logic                  d_uses_rt,
  input  logic [REG_ADDR_W-1:0] d_dst,
  input  logic                  d_rwe,
  input  logic                  d_is_load,
  input  logic                  x_branch_taken,
  output logic                  stall,
  output logic                  bubble_dx,
  output logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [1:0] LS_M1 = 2'(LOAD_STALLS - 1);

  // Shadow entries. The M/W entry never feeds a decision (the register file's
  // write-before-read covers it), so only D/X and X/M state is held.
  logic                  r_dx_vld;
  logic [REG_ADDR_W-1:0] r_dx_dst;
  logic                  r_dx_rwe;
  logic                  r_dx_ld;
  logic                  r_xm_vld;
  logic [REG_ADDR_W-1:0] r_xm_dst;
  logic                  r_xm_rwe;

  logic [1:0]            r_stall_ctr;
  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cycles;
  logic [CNT_W-1:0]      r_flush_count;

  logic                  w_ctr_busy;
  logic                  w_detect;
  logic                  w_stall;
  logic                  w_kill;

  function automatic logic produces(input logic                  vld,
                                    input logic                  rwe,
                                    input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] r);
    return vld && rwe && (dst == r) && (r != '0);
  endfunction

  // MX (producer about to be in X/M) has priority over WX.
  function automatic logic [1:0] fwd_sel(input logic                  uses,
                                         input logic [REG_ADDR_W-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses) begin
      if (produces(r_dx_vld, r_dx_rwe, r_dx_dst, r))
        sel = 2'b01;
      else if (produces(r_xm_vld, r_xm_rwe, r_xm_dst, r))
        sel = 2'b10;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Detect: D-stage consumer directly behind a load. A flush or a stall
  // already in progress suppresses it.
  always_comb begin
    w_ctr_busy = (r_stall_ctr != 2'd0);
    w_detect   = !x_branch_taken && d_valid && !w_ctr_busy && r_dx_ld &&
                 ((d_uses_rs && produces(r_dx_vld, r_dx_rwe, r_dx_dst, d_rs)) ||
                  (d_uses_rt && produces(r_dx_vld, r_dx_rwe, r_dx_dst, d_rt)));
    w_stall    = !x_branch_taken && (w_detect || w_ctr_busy);
    w_kill     = w_stall || x_branch_taken;
  end

  // D -> D/X and D/X -> X/M boundary: shadow shift, stall counter, selects
  always_ff @(posedge clock) begin
    r_dx_dst <= d_dst;
    r_dx_rwe <= d_rwe;
    r_dx_ld  <= d_is_load;
    r_xm_dst <= r_dx_dst;
    r_xm_rwe <= r_dx_rwe;
    if (reset) begin
      r_dx_vld    <= 1'b0;
      r_xm_vld    <= 1'b0;
      r_stall_ctr <= 2'd0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
    end else begin
      r_xm_vld <= r_dx_vld;
      r_dx_vld <= d_valid && !w_kill;
      if (x_branch_taken)
        r_stall_ctr <= 2'd0;
      else if (w_detect)
        r_stall_ctr <= LS_M1;
      else if (w_ctr_busy)
        r_stall_ctr <= r_stall_ctr - 2'd1;
      if (w_kill) begin
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
      end else begin
        r_fwd_a <= fwd_sel(d_uses_rs, d_rs);
        r_fwd_b <= fwd_sel(d_uses_rt, d_rt);
      end
    end
  end

  // Statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall)
        r_stall_cycles <= sat_inc(r_stall_cycles);
      if (x_branch_taken)
        r_flush_count <= sat_inc(r_flush_count);
    end
  end

  assign stall        = w_stall;
  assign bubble_dx    = w_stall;
  assign flush        = x_branch_taken;
  assign fwd_a_sel    = r_fwd_a;
  assign fwd_b_sel    = r_fwd_b;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       d_uses_rs, d_uses_rt, d_rwe, d_is_load, x_branch_taken;

  logic        stall1, bub1, flush1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1, fc1;
  logic        stall3, bub3, flush3;
  logic [1:0]  fa3, fb3;
  logic [3:0]  sc3, fc3;

  always #5 clock = ~clock;

  hazard_unit #(.REG_ADDR_W(5), .LOAD_STALLS(1), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_dst(d_dst), .d_rwe(d_rwe),
    .d_is_load(d_is_load), .x_branch_taken(x_branch_taken), .stall(stall1),
    .bubble_dx(bub1), .flush(flush1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .stall_cycles(sc1), .flush_count(fc1));

  hazard_unit #(.REG_ADDR_W(5), .LOAD_STALLS(3), .CNT_W(4)) u_dut3 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_dst(d_dst), .d_rwe(d_rwe),
    .d_is_load(d_is_load), .x_branch_taken(x_branch_taken), .stall(stall3),
    .bubble_dx(bub3), .flush(flush3), .fwd_a_sel(fa3), .fwd_b_sel(fb3),
    .stall_cycles(sc3), .flush_count(fc3));

  localparam int SIG_STALL = 0;
  localparam int SIG_BUB   = 1;
  localparam int SIG_FLUSH = 2;
  localparam int SIG_FA    = 3;
  localparam int SIG_FB    = 4;
  localparam int SIG_SC    = 5;
  localparam int SIG_FC    = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sel3    = 1'b0;

  function automatic logic [31:0] obs(input int sig);
    logic [31:0] o;
    o = '0;
    case (sig)
      SIG_STALL: o = sel3 ? 32'(stall3) : 32'(stall1);
      SIG_BUB:   o = sel3 ? 32'(bub3)   : 32'(bub1);
      SIG_FLUSH: o = sel3 ? 32'(flush3) : 32'(flush1);
      SIG_FA:    o = sel3 ? 32'(fa3)    : 32'(fa1);
      SIG_FB:    o = sel3 ? 32'(fb3)    : 32'(fb1);
      SIG_SC:    o = sel3 ? 32'(sc3)    : 32'(sc1);
      SIG_FC:    o = sel3 ? 32'(fc3)    : 32'(fc1);
      default:   o = 'x;
    endcase
    return o;
  endfunction

  task automatic push(input string tag, input int sig, input int e);
    exp_t x;
    x.tag = tag;
    x.sig = sig;
    x.exp = 32'(e);
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sig);
      n_tests++;
      assert (o === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
      end
    end
  endtask

  // One D-stage cycle: drive, check combinational outputs, clock, check selects.
  task automatic step(input string tag, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt,
                      input logic [4:0] dst, input logic rwe, input logic ld,
                      input logic br, input int es, input int ef,
                      input int efa, input int efb);
    d_valid = v; d_rs = rs; d_rt = rt; d_uses_rs = urs; d_uses_rt = urt;
    d_dst = dst; d_rwe = rwe; d_is_load = ld; x_branch_taken = br;
    #1;
    push({tag, "_stall"}, SIG_STALL, es);
    push({tag, "_bubble"}, SIG_BUB, es);
    push({tag, "_flush"}, SIG_FLUSH, ef);
    drain();
    @(posedge clock);
    #1;
    push({tag, "_fwd_a"}, SIG_FA, efa);
    push({tag, "_fwd_b"}, SIG_FB, efb);
    drain();
  endtask

  task automatic chk_cnt(input string tag, input int esc, input int efc);
    push({tag, "_stall_cycles"}, SIG_SC, esc);
    push({tag, "_flush_count"}, SIG_FC, efc);
    drain();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_valid = 0; d_rs = 0; d_rt = 0; d_uses_rs = 0; d_uses_rt = 0;
    d_dst = 0; d_rwe = 0; d_is_load = 0; x_branch_taken = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      sel3 = (s == 1);
      push("rst_stall", SIG_STALL, 0);
      push("rst_bubble", SIG_BUB, 0);
      push("rst_flush", SIG_FLUSH, 0);
      push("rst_fwd_a", SIG_FA, 0);
      push("rst_fwd_b", SIG_FB, 0);
      push("rst_stall_cycles", SIG_SC, 0);
      push("rst_flush_count", SIG_FC, 0);
      drain();
    end

    // ---------------- LOAD_STALLS = 1 instance ----------------
    sel3 = 1'b0;
    //          tag        v rs  rt urs urt dst rwe ld br  st fl fa fb
    step("alu_add",   1, 1,  2, 1, 1,  3,  1, 0, 0,  0, 0, 0, 0);
    step("alu_sub",   1, 3,  1, 1, 1,  4,  1, 0, 0,  0, 0, 1, 0);
    step("one_add",   1, 1,  2, 1, 1,  3,  1, 0, 0,  0, 0, 0, 0);
    step("one_nop",   1, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0);
    step("one_or",    1, 1,  3, 1, 1,  5,  1, 0, 0,  0, 0, 0, 2);
    step("pri_add1",  1, 1,  2, 1, 1,  3,  1, 0, 0,  0, 0, 0, 0);
    step("pri_add2",  1, 1,  2, 1, 1,  3,  1, 0, 0,  0, 0, 0, 0);
    step("pri_or",    1, 3,  0, 1, 1,  5,  1, 0, 0,  0, 0, 1, 0);
    step("nouse",     1, 5,  5, 0, 1,  6,  1, 0, 0,  0, 0, 0, 1);
    step("r0_prod",   1, 1,  2, 1, 1,  0,  1, 0, 0,  0, 0, 0, 0);
    step("r0_cons",   1, 0,  0, 1, 1,  4,  1, 0, 0,  0, 0, 0, 0);
    step("r0_lw",     1, 1,  0, 1, 0,  0,  1, 1, 0,  0, 0, 0, 0);
    step("r0_lwuse",  1, 0,  0, 1, 1,  4,  1, 0, 0,  0, 0, 0, 0);
    chk_cnt("no_stall_yet", 0, 0);
    step("lu1_lw",    1, 1,  0, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0);
    step("lu1_stall", 1, 2,  2, 1, 1,  4,  1, 0, 0,  1, 0, 0, 0);
    step("lu1_exec",  1, 2,  2, 1, 1,  4,  1, 0, 0,  0, 0, 2, 2);
    chk_cnt("lu1", 1, 0);
    step("fl_lw",     1, 1,  0, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0);
    step("fl_detect", 1, 2,  2, 1, 1,  4,  1, 0, 1,  0, 1, 0, 0);
    chk_cnt("fl", 1, 1);
    step("fl_after",  1, 2,  2, 1, 1,  4,  1, 0, 0,  0, 0, 2, 2);
    step("fl_plain",  1, 0,  0, 0, 0,  0,  0, 0, 1,  0, 1, 0, 0);
    chk_cnt("fl2", 1, 2);

    // ---------------- LOAD_STALLS = 3, CNT_W = 4 instance ----------------
    sel3 = 1'b1;
    do_reset();
    chk_cnt("rst3", 0, 0);
    step("lu3_lw",    1, 1,  0, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0);
    step("lu3_s1",    1, 2,  2, 1, 1,  4,  1, 0, 0,  1, 0, 0, 0);
    step("lu3_s2",    1, 2,  2, 1, 1,  4,  1, 0, 0,  1, 0, 0, 0);
    step("lu3_s3",    1, 2,  2, 1, 1,  4,  1, 0, 0,  1, 0, 0, 0);
    step("lu3_exec",  1, 2,  2, 1, 1,  4,  1, 0, 0,  0, 0, 0, 0);
    chk_cnt("lu3", 3, 0);
    step("fl3_lw",    1, 1,  0, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0);
    step("fl3_det",   1, 2,  2, 1, 1,  4,  1, 0, 1,  0, 1, 0, 0);
    step("fl3_after", 1, 2,  2, 1, 1,  4,  1, 0, 0,  0, 0, 2, 2);
    chk_cnt("fl3", 3, 1);

    for (int k = 0; k < 6; k++) begin
      step("sat_lw", 1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++)
        step("sat_use", 1, 2, 2, 1, 1, 4, 1, 0, 0, (c < 3) ? 1 : 0, 0, 0, 0);
      chk_cnt("sat", (3 + 3 * (k + 1) > 15) ? 15 : 3 + 3 * (k + 1), 1);
    end

    step("mid_lw",    1, 1,  0, 1, 0,  2,  1, 1, 0,  0, 0, 0, 0);
    step("mid_s1",    1, 2,  2, 1, 1,  4,  1, 0, 0,  1, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    push("mid_rst_stall", SIG_STALL, 0);
    push("mid_rst_fwd_a", SIG_FA, 0);
    drain();
    chk_cnt("mid_rst", 0, 0);
    step("mid_cont",  1, 2,  2, 1, 1,  4,  1, 0, 0,  0, 0, 0, 0);
    chk_cnt("mid_cont", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (F, D, X, M, W). It replaces the ad-hoc MX/WX bypass compare done at the pipeline level with a self-contained unit. The unit keeps its own shadow copy of destination and load information for the DX, XM and MW stages. From that state it produces registered forwarding selects for X, load-use stalls of configurable length, taken-branch flushes, and saturating stall/flush statistics.

## Interface
- `REG_ADDR_W`, default 5: register-specifier width; register 0 is hard-wired zero.
- `LOAD_STALLS`, default 1: stall cycles per load-use hazard, legal range 1..3.
- `CNT_W`, default 16: width of the statistics counters.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `d_valid`  in  1  F/D holds a real instruction.
- `d_rs`, `d_rt`  in  REG_ADDR_W  source specifiers of the instruction in D.
- `d_uses_rs`, `d_uses_rt`  in  1  the instruction in D reads rs / rt.
- `d_dst`  in  REG_ADDR_W  destination specifier, already resolved rt/rd by the `rdst` mux.
- `d_rwe`  in  1  the instruction in D writes the register file.
- `d_is_load`  in  1  the instruction in D is a load.
- `x_branch_taken`  in  1  the instruction in X resolved as a taken branch or jump (`do_branch`).
- `stall`  out  1  hold PC and F/D this cycle.
- `bubble_dx`  out  1  load a NOP (all control zero) into D/X at the next edge.
- `flush`  out  1  squash F/D and D/X at the next edge.
- `fwd_a_sel`, `fwd_b_sel`  out  2  X-stage operand source: 00 = D/X register value, 01 = MX (`aluOut_XM`), 10 = WX (writeback `dataout`); 11 is never driven.
- `stall_cycles`, `flush_count`  out  CNT_W  saturating statistics counters.

## Operation
- **Shadow pipeline.** Three entries, `sdx`, `sxm`, `smw`, each holding {valid, dst, rwe, is_load}.
- **Normal edge.** `smw <= sxm`, `sxm <= sdx`, `sdx <= {d_valid, d_dst, d_rwe, d_is_load}`.
- **Bubble or flush edge.** `sdx` valid is cleared; `sxm` and `smw` still shift.
- **Producer match.** An entry "produces r" when valid, rwe, dst == r and r != 0.
- **Load-use detect (combinational).** Asserted when d_valid, `sdx` is a load producing d_rs with d_uses_rs (or d_rt with d_uses_rt), and no stall is in progress. On detect, `stall_ctr <= LOAD_STALLS - 1`.
- **Stall output.** `stall = detect | (stall_ctr != 0)`; `bubble_dx = stall`. Each stalled cycle after detect decrements `stall_ctr`.
- **Forward selects (registered).** Computed at the edge the D instruction enters D/X. Valid during that instruction's X cycle.
  - 01 if the current `sdx` produces the source (it will be in X/M).
  - else 10 if the current `sxm` produces the source (it will be in M/W).
  - else 00.
  - MX has priority over WX. A source with uses = 0 gets 00.
- **Selects during bubble or flush.** On a bubble or flush edge, fwd selects load 00.
- **Flush.** `flush = x_branch_taken`. A flush clears `stall_ctr` and suppresses `detect`, so flush wins over stall.
- **Counters.**
  - `stall_cycles` increments on each cycle with stall = 1.
  - `flush_count` increments on each flush cycle.
  - Both saturate at all-ones.
- **Out of scope.** Register reads in D of a register being written from M/W are covered by register-file write-before-read; this unit does not handle them.

## Timing
- **Reset.** At the first edge with reset = 1: all shadow valids 0, `stall_ctr` 0, fwd selects 00, counters 0. Hence stall, bubble_dx and flush are 0 once reset is applied, provided x_branch_taken = 0.
- **Reset mid-stall.** Aborts the stall at that edge.
- **Output paths.** stall, bubble_dx and flush are combinational from inputs and state. fwd selects and counters are registers.
- **Load-use latency.** A consumer directly behind a load stalls exactly LOAD_STALLS cycles.
  - LOAD_STALLS = 1: the consumer then executes with select 10 (WX).
  - LOAD_STALLS >= 2: the consumer executes with select 00.
- **Re-evaluation while stalled.** The D instruction is re-evaluated every cycle; the selects latched when it finally enters D/X reflect the shadow state at that edge.
- **Back-to-back loads.** A new hazard cannot be detected until `stall_ctr` has reached 0.
- **Non-load producers.** A producer in `sdx` that is not a load never stalls.

## Test plan
- **ALU chain.** `add r3,r1,r2` followed by `sub r4,r3,r1` -> fwd_a_sel = 01 in sub's X cycle; no stall.
- **One-apart dependency.** `add r3`, `nop`, `or r5,r1,r3` -> fwd_b_sel = 10; `add r3`, `add r3`, `or r5,r3,r0` -> fwd_a_sel = 01 (MX priority).
- **Load-use.** `lw r2,0(r1)` followed by `add r4,r2,r2` with LOAD_STALLS = 1 -> stall = 1 for 1 cycle, bubble in D/X, then fwd_a_sel = fwd_b_sel = 10, stall_cycles = 1. With LOAD_STALLS = 3 -> 3 stall cycles, selects 00, stall_cycles = 3.
- **Register zero.** `lw r0` followed by `add r4,r0,r0` -> no stall, selects 00; `add r0,...` producer -> never forwarded.
- **Flush over stall.** x_branch_taken = 1 in the same cycle as a load-use detect -> flush = 1, stall = 0, stall_ctr = 0, flush_count += 1, next D/X entry invalid.
- **Saturation and reset.** With CNT_W = 4, drive 20 stall cycles -> stall_cycles = 15. Assert reset during a LOAD_STALLS = 3 stall -> stall = 0 after the edge, counters 0.
